rgb_to_ycbcr_blk: RTL and testbench

RGB_TO_YCBCR_BLK -- requirements
Module: rgb_to_ycbcr_blk

---
 rtl/jpeg_color_pkg.sv | 37 +++
 rtl/rgb_to_ycbcr_px.sv | 56 +++++
 rtl/rgb_to_ycbcr_blk.sv | 95 +++++++++
 tb/tb_rgb_to_ycbcr_blk.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_color_pkg.sv
// Constants and pixel type shared by the encoder-side (RGB->YCbCr) and decoder-side colour converters.
// The Q8 coefficients below are BT.601 full-range values scaled by 256.
package jpeg_color_pkg;

  localparam int BLK_PIXELS = 64;
  localparam int FRAC_BITS  = 8;
  localparam int SUM_W      = 18;

  localparam int C_Y_R  = 77;
  localparam int C_Y_G  = 150;
  localparam int C_Y_B  = 29;
  localparam int C_CB_R = -43;
  localparam int C_CB_G = -85;
  localparam int C_CB_B = 128;
  localparam int C_CR_R = 128;
  localparam int C_CR_G = -107;
  localparam int C_CR_B = -21;

  localparam int ROUND_K    = 128;
  localparam int CHROMA_OFS = 128;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef logic signed [SUM_W-1:0] sum_t;

  // Rounded dot product of one pixel with one coefficient row; the worst case, 256*255+128, fits in SUM_W.
  function automatic sum_t mac3(input pixel_t p, input int c_r, input int c_g, input int c_b);
    int acc;
    acc = c_r * int'({24'd0, p.r}) + c_g * int'({24'd0, p.g}) + c_b * int'({24'd0, p.b}) + ROUND_K;
    return sum_t'(acc);
  endfunction

endpackage

// File: rtl/rgb_to_ycbcr_px.sv
// Two-stage per-pixel RGB->YCbCr datapath: stage 1 registers the Q8 sums, stage 2 scales and offsets them.
// Define RGB2YCC_CLAMP_EN to saturate results to [0,255]; otherwise the results wrap to 8 bits.
module rgb_to_ycbcr_px
  import jpeg_color_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  pixel_t     i_pix,
  output logic       o_valid,
  output logic [7:0] o_y,
  output logic [7:0] o_cb,
  output logic [7:0] o_cr
);

  logic r_s1_vld;
  sum_t r_sum_y;
  sum_t r_sum_cb;
  sum_t r_sum_cr;

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_sum_y  <= '0;
      r_sum_cb <= '0;
      r_sum_cr <= '0;
    end else begin
      r_s1_vld <= i_valid;
      if (i_valid) begin
        r_sum_y  <= mac3(i_pix, C_Y_R,  C_Y_G,  C_Y_B);
        r_sum_cb <= mac3(i_pix, C_CB_R, C_CB_G, C_CB_B);
        r_sum_cr <= mac3(i_pix, C_CR_R, C_CR_G, C_CR_B);
      end
    end
  end

  function automatic logic [7:0] post(input sum_t s, input int ofs);
    sum_t v;
    v = (s >>> FRAC_BITS) + sum_t'(ofs);
`ifdef RGB2YCC_CLAMP_EN
    if (v[SUM_W-1]) begin
      return 8'd0;
    end else if (|v[SUM_W-2:8]) begin
      return 8'd255;
    end
`endif
    return 8'(v);
  endfunction

  assign o_valid = r_s1_vld;
  assign o_y     = post(r_sum_y,  0);
  assign o_cb    = post(r_sum_cb, CHROMA_OFS);
  assign o_cr    = post(r_sum_cr, CHROMA_OFS);

endmodule

// File: rtl/rgb_to_ycbcr_blk.sv
// 8x8 block RGB->YCbCr converter: accepts 64 pixels in raster order, presents full Y/Cb/Cr blocks.
// Saturation versus wrap is selected by RGB2YCC_CLAMP_EN inside rgb_to_ycbcr_px.
module rgb_to_ycbcr_blk
  import jpeg_color_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [7:0]           r,
  input  logic [7:0]           g,
  input  logic [7:0]           b,
  output logic                 ready_out,
  output logic [7:0][7:0][7:0] y,
  output logic [7:0][7:0][7:0] cb,
  output logic [7:0][7:0][7:0] cr,
  output logic                 valid_out,
  input  logic                 ready_in
);

  localparam int CNT_W = $clog2(BLK_PIXELS + 1);
  localparam int IDX_W = $clog2(BLK_PIXELS);

  logic [CNT_W-1:0]     r_acc_cnt;
  logic [IDX_W-1:0]     r_wr_idx;
  logic                 r_valid_out;
  logic [7:0][7:0][7:0] r_y;
  logic [7:0][7:0][7:0] r_cb;
  logic [7:0][7:0][7:0] r_cr;

  logic       w_accept;
  logic       w_release;
  logic       w_px_vld;
  pixel_t     w_pix;
  logic [7:0] w_y;
  logic [7:0] w_cb;
  logic [7:0] w_cr;

  assign ready_out = !rst && (r_acc_cnt != CNT_W'(BLK_PIXELS));
  assign w_accept  = valid_in && ready_out;
  assign w_release = r_valid_out && ready_in;
  assign w_pix     = '{r: r, g: g, b: b};

  rgb_to_ycbcr_px u_px (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_accept),
    .i_pix   (w_pix),
    .o_valid (w_px_vld),
    .o_y     (w_y),
    .o_cb    (w_cb),
    .o_cr    (w_cr)
  );

  // The accept count stops at 64, so the pipeline is already empty when the block is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_cnt   <= '0;
      r_wr_idx    <= '0;
      r_valid_out <= 1'b0;
    end else if (w_release) begin
      r_acc_cnt   <= '0;
      r_wr_idx    <= '0;
      r_valid_out <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc_cnt <= r_acc_cnt + 1'b1;
      end
      if (w_px_vld) begin
        r_wr_idx <= r_wr_idx + 1'b1;
        if (r_wr_idx == IDX_W'(BLK_PIXELS - 1)) begin
          r_valid_out <= 1'b1;
        end
      end
    end
  end

  // NOTE: the block buffers are reset on purpose so a reset mid-block can never expose stale pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y  <= '0;
      r_cb <= '0;
      r_cr <= '0;
    end else if (w_px_vld) begin
      r_y [r_wr_idx[5:3]][r_wr_idx[2:0]] <= w_y;
      r_cb[r_wr_idx[5:3]][r_wr_idx[2:0]] <= w_cb;
      r_cr[r_wr_idx[5:3]][r_wr_idx[2:0]] <= w_cr;
    end
  end

  assign valid_out = r_valid_out;
  assign y         = r_y;
  assign cb        = r_cb;
  assign cr        = r_cr;

endmodule

// File: tb/tb_rgb_to_ycbcr_blk.sv
// Directed, table-driven bench for rgb_to_ycbcr_blk; expected values follow RGB2YCC_CLAMP_EN if defined.
module tb_rgb_to_ycbcr_blk;

  logic                 clk;
  logic                 rst;
  logic                 valid_in;
  logic [7:0]           r;
  logic [7:0]           g;
  logic [7:0]           b;
  logic                 ready_out;
  logic [7:0][7:0][7:0] y;
  logic [7:0][7:0][7:0] cb;
  logic [7:0][7:0][7:0] cr;
  logic                 valid_out;
  logic                 ready_in;

  int checks   = 0;
  int failures = 0;

`ifdef RGB2YCC_CLAMP_EN
  localparam logic [7:0] OVF = 8'd255;
`else
  localparam logic [7:0] OVF = 8'd0;
`endif

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] ey;
    logic [7:0] ecb;
    logic [7:0] ecr;
  } vec_t;

  vec_t vecs[7];

  rgb_to_ycbcr_blk dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .r         (r),
    .g         (g),
    .b         (b),
    .ready_out (ready_out),
    .y         (y),
    .cb        (cb),
    .cr        (cr),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] fix8(input int v);
`ifdef RGB2YCC_CLAMP_EN
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
`endif
    return v[7:0];
  endfunction

  function automatic logic [23:0] golden(input int rr, input int gg, input int bb);
    int yy, cbv, crv;
    yy  = (77 * rr + 150 * gg + 29 * bb + 128) >>> 8;
    cbv = ((-43 * rr - 85 * gg + 128 * bb + 128) >>> 8) + 128;
    crv = ((128 * rr - 107 * gg - 21 * bb + 128) >>> 8) + 128;
    return {fix8(yy), fix8(cbv), fix8(crv)};
  endfunction

  function automatic logic [23:0] px_at(input int idx);
    return {y[idx >> 3][idx & 7], cb[idx >> 3][idx & 7], cr[idx >> 3][idx & 7]};
  endfunction

  task automatic check_block(input string name, input logic [23:0] exp);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s[%0d][%0d]", name, i >> 3, i & 7), {8'h0, px_at(i)}, {8'h0, exp});
    end
  endtask

  task automatic push(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    r = rr;
    g = gg;
    b = bb;
    valid_in = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string name, input int max_edges);
    int n;
    n = 0;
    while (!valid_out && n < max_edges) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_valid_out"}, {31'h0, valid_out}, 32'h1);
  endtask

  task automatic release_blk(input string name);
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    check({name, "_rel_valid_out"}, {31'h0, valid_out}, 32'h0);
    check({name, "_rel_ready_out"}, {31'h0, ready_out}, 32'h1);
  endtask

  task automatic pulse_reset();
    valid_in = 1'b0;
    ready_in = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'd255, 8'd0,   8'd0,   8'd77,  8'd85,  OVF};
    vecs[1] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd128, 8'd128};
    vecs[2] = '{8'd0,   8'd255, 8'd0,   8'd149, 8'd43,  8'd21};
    vecs[3] = '{8'd0,   8'd0,   8'd255, 8'd29,  OVF,    8'd107};
    vecs[4] = '{8'd100, 8'd50,  8'd200, 8'd82,  8'd195, 8'd141};
    vecs[5] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128};
    vecs[6] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};

    rst = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    r = '0;
    g = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_out", {31'h0, ready_out}, 32'h0);
    check("rst_valid_out", {31'h0, valid_out}, 32'h0);
    check_block("rst_buf", 24'h000000);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_out", {31'h0, ready_out}, 32'h1);
    @(posedge clk); #1;

    // White block streamed back-to-back: pixel 63 is accepted on edge 64 and written on edge 65.
    for (int k = 0; k < 64; k++) push(8'd255, 8'd255, 8'd255);
    valid_in = 1'b0;
    check("white_e64_valid_out", {31'h0, valid_out}, 32'h0);
    check("white_e64_ready_out", {31'h0, ready_out}, 32'h0);
    @(posedge clk); #1;
    check("white_e65_valid_out", {31'h0, valid_out}, 32'h1);
    @(posedge clk); #1;
    check_block("white", 24'hFF8080);

    // Consumer stalls for 10 cycles while a 65th pixel is offered.
    r = 8'd0; g = 8'd0; b = 8'd0;
    valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_ready_out", i), {31'h0, ready_out}, 32'h0);
      check($sformatf("stall%0d_valid_out", i), {31'h0, valid_out}, 32'h1);
    end
    check_block("stall_hold", 24'hFF8080);
    release_blk("stall");
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("p65_latency_hold", {8'h0, px_at(0)}, 32'hFF8080);
    @(posedge clk); #1;
    check("p65_at_0_0", {8'h0, px_at(0)}, 32'h008080);
    check("p65_0_1_kept", {8'h0, px_at(1)}, 32'hFF8080);
    pulse_reset();

    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 64; k++) push(vecs[v].r, vecs[v].g, vecs[v].b);
      valid_in = 1'b0;
      wait_valid($sformatf("vec%0d", v), 4);
      check_block($sformatf("vec%0d", v), {vecs[v].ey, vecs[v].ecb, vecs[v].ecr});
      release_blk($sformatf("vec%0d", v));
    end

    // Black with valid_in on every other cycle: last acceptance on edge 127, write on edge 128.
    r = 8'd0; g = 8'd0; b = 8'd0;
    for (int i = 0; i < 127; i++) begin
      valid_in = (i % 2 == 0);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    check("toggle_e127_valid_out", {31'h0, valid_out}, 32'h0);
    check("toggle_e127_ready_out", {31'h0, ready_out}, 32'h0);
    @(posedge clk); #1;
    check("toggle_e128_valid_out", {31'h0, valid_out}, 32'h1);
    check_block("toggle", 24'h008080);
    release_blk("toggle");

    for (int k = 0; k < 64; k++) push(8'(k), 8'(2 * k), 8'(3 * k));
    valid_in = 1'b0;
    wait_valid("ramp", 4);
    for (int k = 0; k < 64; k++) begin
      check($sformatf("ramp[%0d][%0d]", k >> 3, k & 7), {8'h0, px_at(k)}, {8'h0, golden(k, 2 * k, 3 * k)});
    end
    release_blk("ramp");

    // Reset after 30 accepted pixels must discard them and restart the block count.
    for (int k = 0; k < 30; k++) push(8'd255, 8'd255, 8'd255);
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("partial_written", {8'h0, px_at(29)}, 32'hFF8080);
    rst = 1'b1;
    #1;
    check_block("async_rst", 24'h000000);
    check("async_rst_valid_out", {31'h0, valid_out}, 32'h0);
    check("async_rst_ready_out", {31'h0, ready_out}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 63; k++) push(8'd100, 8'd50, 8'd200);
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("fresh63_wait%0d_valid_out", i), {31'h0, valid_out}, 32'h0);
    end
    check("fresh63_ready_out", {31'h0, ready_out}, 32'h1);
    push(8'd100, 8'd50, 8'd200);
    valid_in = 1'b0;
    check("fresh64_e0_valid_out", {31'h0, valid_out}, 32'h0);
    wait_valid("fresh", 4);
    check_block("fresh", 24'h52C38D);
    release_blk("fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
